// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the MEM stage. Data accesses win ties; the optional fetch starvation
// guard (enabled by defining FETCH_STARVE_GUARD_EN) lets a waiting fetch in
// after four data grants made while it was pending.
module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   // instruction fetch requester
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   // MEM stage requester
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   // pipeline stalls
   output logic        stall_if,
   output logic        stall_mem,
   // shared memory port
   output logic        port_req,
   output logic        port_we,
   output logic [31:0] port_addr,
   output logic [31:0] port_wdata,
   input  logic        port_ack,
   input  logic [31:0] port_rdata
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_BUSY_IF  = 3'd1,
      S_BUSY_MEM = 3'd2,
      S_DONE_IF  = 3'd3,
      S_DONE_MEM = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_port_req;
   logic                r_port_we;
   logic [ADDR_W-1:0]   r_port_addr;
   logic [DATA_W-1:0]   r_port_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_mem_rdata;
   logic                r_if_ready;
   logic                r_mem_ready;

   logic                w_mem_pend;
   logic                w_grant_if;
   logic                w_grant_mem;

   assign w_mem_pend = mem_read | mem_write;

`ifdef FETCH_STARVE_GUARD_EN
   localparam int unsigned GUARD_W = 3;
   localparam logic [GUARD_W-1:0] GUARD_LIMIT = GUARD_W'(4);

   logic [GUARD_W-1:0]  r_guard_cnt;

   // Fetch wins when it is alone or when data has starved it long enough
   assign w_grant_if  = if_req & (~w_mem_pend | (r_guard_cnt == GUARD_LIMIT));
   assign w_grant_mem = w_mem_pend & ~w_grant_if;

   // Count data grants that overtook a pending fetch; any other grant clears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_guard_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_grant_if) begin
            r_guard_cnt <= '0;
         end else if (w_grant_mem) begin
            if (if_req) begin
               r_guard_cnt <= r_guard_cnt + GUARD_W'(1);
            end else begin
               r_guard_cnt <= '0;
            end
         end
      end
   end
`else
   // Data access always wins a tie
   assign w_grant_mem = w_mem_pend;
   assign w_grant_if  = if_req & ~w_mem_pend;
`endif

   // Arbitration FSM with registered port request and completion outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_port_req   <= 1'b0;
         r_port_we    <= 1'b0;
         r_port_addr  <= '0;
         r_port_wdata <= '0;
         r_if_rdata   <= '0;
         r_mem_rdata  <= '0;
         r_if_ready   <= 1'b0;
         r_mem_ready  <= 1'b0;
      end else begin
         r_if_ready  <= 1'b0;
         r_mem_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_mem) begin
                  r_port_req   <= 1'b1;
                  r_port_we    <= mem_write;
                  r_port_addr  <= mem_addr;
                  r_port_wdata <= mem_wdata;
                  r_state      <= S_BUSY_MEM;
               end else if (w_grant_if) begin
                  r_port_req   <= 1'b1;
                  r_port_we    <= 1'b0;
                  r_port_addr  <= if_addr;
                  r_state      <= S_BUSY_IF;
               end
            end
            S_BUSY_IF: begin
               if (port_ack) begin
                  r_port_req <= 1'b0;
                  r_if_rdata <= port_rdata;
                  r_if_ready <= 1'b1;
                  r_state    <= S_DONE_IF;
               end
            end
            S_BUSY_MEM: begin
               if (port_ack) begin
                  r_port_req  <= 1'b0;
                  r_mem_rdata <= port_rdata;
                  r_mem_ready <= 1'b1;
                  r_state     <= S_DONE_MEM;
               end
            end
            S_DONE_IF, S_DONE_MEM: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_port_req <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign port_req   = r_port_req;
   assign port_we    = r_port_we;
   assign port_addr  = r_port_addr;
   assign port_wdata = r_port_wdata;
   assign if_rdata   = r_if_rdata;
   assign mem_rdata  = r_mem_rdata;
   assign if_ready   = r_if_ready;
   assign mem_ready  = r_mem_ready;

   // Stalls drop in the same cycle as the matching ready pulse
   assign stall_if  = if_req & ~r_if_ready;
   assign stall_mem = w_mem_pend & ~r_mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand sequences for tie,
// fetch starvation and reset-during-transaction. Read data is checked by a
// scoreboard that pops on every ready pulse.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_mem;
   logic        port_req;
   logic        port_we;
   logic [31:0] port_addr;
   logic [31:0] port_wdata;
   logic        port_ack;
   logic [31:0] port_rdata;

   mem_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_ready   (if_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .stall_if   (stall_if),
      .stall_mem  (stall_mem),
      .port_req   (port_req),
      .port_we    (port_we),
      .port_addr  (port_addr),
      .port_wdata (port_wdata),
      .port_ack   (port_ack),
      .port_rdata (port_rdata)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          is_mem;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;
      bit          exp_we;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs [NVEC];

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_mem_q [$];
   logic [31:0] exp_if_q  [$];
   logic [31:0] grant_q   [$];
   logic        mon_prev_req = 1'b0;
   bit          auto_ack = 1'b1;
   int          ack_delay = 0;

   // Memory contents seen by the responder
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return a ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] pop_grant();
      if (grant_q.size() == 0) return 32'hFFFF_FFFF;
      return grant_q.pop_front();
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor and grant log
   initial begin
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            if (exp_mem_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_mem_ready actual=1 expected=0");
            end else begin
               chk("mem_rdata", mem_rdata, exp_mem_q.pop_front());
            end
         end
         if (if_ready) begin
            if (exp_if_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_if_ready actual=1 expected=0");
            end else begin
               chk("if_rdata", if_rdata, exp_if_q.pop_front());
            end
         end
         if (port_req && !mon_prev_req) grant_q.push_back(port_addr);
         mon_prev_req = port_req;
      end
   end

   // Memory responder: acks ack_delay cycles after seeing port_req
   initial begin
      int wait_cnt;
      wait_cnt   = 0;
      port_ack   = 1'b0;
      port_rdata = '0;
      forever begin
         @(negedge clk);
         if (auto_ack) begin
            if (port_req && !port_ack) begin
               if (wait_cnt >= ack_delay) begin
                  port_ack   = 1'b1;
                  port_rdata = mem_model(port_addr);
                  wait_cnt   = 0;
               end else begin
                  wait_cnt++;
               end
            end else begin
               port_ack = 1'b0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v;
      int          req_cycles;
      bit          done;
      int          cnt, t_mem, t_if, t_ifgrant, loads;
      bit          mem_done, if_done;
      logic [31:0] exp_order [6];

      vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 1'b1, 32'h5A5A_5A1A};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 0, 1'b0, 32'h5A5A_5A5E};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 0, 1'b1, 32'h5A5A_585A};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 3, 1'b0, 32'hA5A5_A5A6};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0BAD_F00D, 1, 1'b0, 32'hDA5A_5A5A};

      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_port_req",   32'(port_req),   32'h0);
      chk("rst_port_we",    32'(port_we),    32'h0);
      chk("rst_port_addr",  port_addr,       32'h0);
      chk("rst_port_wdata", port_wdata,      32'h0);
      chk("rst_if_rdata",   if_rdata,        32'h0);
      chk("rst_mem_rdata",  mem_rdata,       32'h0);
      chk("rst_readies",    32'({if_ready, mem_ready}), 32'h0);
      chk("rst_stalls",     32'({stall_if, stall_mem}), 32'h0);
      rst = 1'b0;

      // Table-driven single transactions
      for (int i = 0; i < NVEC; i++) begin
         v = vecs[i];
         @(negedge clk);
         ack_delay = v.delay;
         if (v.is_mem) begin
            mem_read = v.rd; mem_write = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
            exp_mem_q.push_back(v.exp_rdata);
         end else begin
            if_req = 1'b1; if_addr = v.addr;
            exp_if_q.push_back(v.exp_rdata);
         end
         req_cycles = 0;
         done = 1'b0;
         for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (port_req) begin
               req_cycles++;
               chk("port_addr", port_addr, v.addr);
               chk("port_we", 32'(port_we), 32'(v.exp_we));
               if (v.is_mem) begin
                  chk("port_wdata", port_wdata, v.wdata);
                  chk("stall_mem_busy", 32'(stall_mem), 32'h1);
               end else begin
                  chk("stall_if_busy", 32'(stall_if), 32'h1);
               end
               // requester inputs are don't-care once latched
               mem_addr = $urandom; mem_wdata = $urandom; if_addr = $urandom;
            end
            if (v.is_mem ? mem_ready : if_ready) begin
               done = 1'b1;
               chk("stall_at_ready", 32'(v.is_mem ? stall_mem : stall_if), 32'h0);
            end
         end
         if (!done) begin
            checks++; failures++;
            $display("FAIL ready_timeout vec=%0d actual=none expected=pulse", i);
         end
         chk("port_req_cycles", 32'(req_cycles), 32'(v.delay + 1));
         mem_read = 1'b0; mem_write = 1'b0; if_req = 1'b0;
         @(negedge clk);
         chk("ready_one_cycle", 32'({if_ready, mem_ready}), 32'h0);
         chk("rdata_hold", v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
      end

      // Tie: MEM first, IF granted in the IDLE cycle after DONE_MEM
      @(negedge clk);
      ack_delay = 0;
      grant_q.delete();
      mem_read = 1'b1; mem_addr = 32'h0000_0600; if_req = 1'b1; if_addr = 32'h0000_0008;
      exp_mem_q.push_back(32'h5A5A_5C5A);
      exp_if_q.push_back(32'h5A5A_5A52);
      cnt = 0; t_mem = -1; t_if = -1; t_ifgrant = -1;
      mem_done = 1'b0; if_done = 1'b0;
      while (cnt < 40 && !(mem_done && if_done)) begin
         @(negedge clk);
         cnt++;
         if (port_req && port_addr == 32'h0000_0008 && t_ifgrant < 0) t_ifgrant = cnt;
         if (mem_ready) begin mem_read = 1'b0; t_mem = cnt; mem_done = 1'b1; end
         if (if_ready)  begin if_req = 1'b0;   t_if = cnt;  if_done = 1'b1; end
      end
      chk("tie_both_done", 32'({mem_done, if_done}), 32'h3);
      chk("tie_first_grant", pop_grant(), 32'h0000_0600);
      chk("tie_second_grant", pop_grant(), 32'h0000_0008);
      chk("tie_if_grant_gap", 32'(t_ifgrant - t_mem), 32'h2);
      chk("tie_if_after_mem", 32'(t_if > t_mem), 32'h1);

      // Fetch held while five back-to-back loads arrive
      @(negedge clk);
      grant_q.delete();
`ifdef FETCH_STARVE_GUARD_EN
      exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h4, 32'h300};
`else
      exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h4};
`endif
      mem_read = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = '0;
      if_req = 1'b1; if_addr = 32'h0000_0004;
      for (int k = 0; k < 5; k++) exp_mem_q.push_back(32'h5A5A_595A);
      exp_if_q.push_back(32'h5A5A_5A5E);
      cnt = 0; loads = 0; mem_done = 1'b0; if_done = 1'b0;
      while (cnt < 200 && !(mem_done && if_done)) begin
         @(negedge clk);
         cnt++;
         if (mem_ready) begin
            loads++;
            if (loads == 5) begin mem_read = 1'b0; mem_done = 1'b1; end
         end
         if (if_ready) begin if_req = 1'b0; if_done = 1'b1; end
      end
      chk("starve_both_done", 32'({mem_done, if_done}), 32'h3);
      for (int k = 0; k < 6; k++) chk("starve_grant_order", pop_grant(), exp_order[k]);

      // Reset during BUSY_MEM, then a late ack
      @(negedge clk);
      auto_ack = 1'b0;
      port_ack = 1'b0;
      mem_write = 1'b1; mem_addr = 32'h0000_0500; mem_wdata = 32'h0000_55AA;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         if (port_req) done = 1'b1;
      end
      chk("rstbusy_granted", 32'(done), 32'h1);
      rst = 1'b1;
      #1;
      chk("rstbusy_port_req",   32'(port_req), 32'h0);
      chk("rstbusy_port_we",    32'(port_we),  32'h0);
      chk("rstbusy_port_addr",  port_addr,     32'h0);
      chk("rstbusy_port_wdata", port_wdata,    32'h0);
      chk("rstbusy_mem_rdata",  mem_rdata,     32'h0);
      chk("rstbusy_if_rdata",   if_rdata,      32'h0);
      chk("rstbusy_readies",    32'({if_ready, mem_ready}), 32'h0);
      mem_write = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      port_ack = 1'b1; port_rdata = 32'hBAD0_BAD0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 1) port_ack = 1'b0;
         chk("late_ack_no_ready", 32'(mem_ready), 32'h0);
         chk("late_ack_no_req",   32'(port_req),  32'h0);
         chk("late_ack_rdata",    mem_rdata,      32'h0);
      end

      // Operation resumes after reset
      auto_ack = 1'b1; ack_delay = 1;
      mem_read = 1'b1; mem_addr = 32'h0000_0100;
      exp_mem_q.push_back(32'hDEAD_BEEF);
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (mem_ready) begin done = 1'b1; mem_read = 1'b0; end
      end
      chk("resume_ready", 32'(done), 32'h1);

      repeat (3) @(negedge clk);
      chk("mem_q_drained", 32'(exp_mem_q.size()), 32'h0);
      chk("if_q_drained",  32'(exp_if_q.size()),  32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
